// File: rtl/vote_result_resolver.sv
// Vote result resolver.
//
// Snapshots four candidate tallies on a start request in result mode, scans
// them one entry per clock, then presents the winner on a valid/ack handshake.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   mode           0 = voting mode, 1 = result mode
//   start          resolve request, level-sampled
//   cand1..4_vote  per-candidate tallies (index 0..3)
//   ack            consumer has taken the result
//   busy           high while scanning
//   result_valid   high while the result is presented
//   winner         index of the highest tally (lowest index on a tie)
//   winner_count   highest tally value
//   tie            two or more candidates share a nonzero maximum
//   no_votes       all tallies are zero
//   total_votes    sum of the four tallies
module vote_result_resolver #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] cand1_vote,
  input  logic [CNT_W-1:0] cand2_vote,
  input  logic [CNT_W-1:0] cand3_vote,
  input  logic [CNT_W-1:0] cand4_vote,
  input  logic             ack,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] winner_count,
  output logic             tie,
  output logic             no_votes,
  output logic [CNT_W+1:0] total_votes
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HoldLast = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0][CNT_W-1:0]   snap_q, snap_d;
  logic [1:0]              winner_q, winner_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    tie_q, tie_d;
  logic                    no_votes_q, no_votes_d;
  logic [CNT_W+1:0]        total_q, total_d;
  logic [HW-1:0]           hold_q, hold_d;

  logic [CNT_W-1:0]        entry;
  logic                    hold_done;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    winner_d   = winner_q;
    count_d    = count_q;
    tie_d      = tie_q;
    no_votes_d = no_votes_q;
    total_d    = total_q;
    hold_d     = hold_q;
    entry      = snap_q[idx_q[1:0]];
    hold_done  = (HOLD_CYCLES != 0) && (hold_q == HoldLast);

    case (state_q)
      StIdle: begin
        if (start && mode) begin
          snap_d     = {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
          winner_d   = '0;
          count_d    = '0;
          tie_d      = 1'b0;
          no_votes_d = 1'b0;
          total_d    = '0;
          idx_d      = '0;
          state_d    = StScan;
        end
      end

      StScan: begin
        if (!mode) begin
          // Abort: drop partial results so nothing stale is shown.
          winner_d   = '0;
          count_d    = '0;
          tie_d      = 1'b0;
          no_votes_d = 1'b0;
          total_d    = '0;
          idx_d      = '0;
          state_d    = StIdle;
        end else if (idx_q == 3'd4) begin
          // Commit cycle after the last entry; a zero maximum is never a tie.
          no_votes_d = (total_q == '0);
          if (count_q == '0) tie_d = 1'b0;
          hold_d     = '0;
          idx_d      = '0;
          state_d    = StDone;
        end else begin
          if (idx_q == 3'd0) begin
            count_d  = entry;
            winner_d = 2'd0;
            tie_d    = 1'b0;
            total_d  = {2'b00, entry};
          end else begin
            if (entry > count_q) begin
              count_d  = entry;
              winner_d = idx_q[1:0];
              tie_d    = 1'b0;
            end else if (entry == count_q) begin
              tie_d = 1'b1;
            end
            total_d = total_q + {2'b00, entry};
          end
          idx_d = idx_q + 3'd1;
        end
      end

      StDone: begin
        if (ack || !mode || hold_done) begin
          hold_d  = '0;
          state_d = StIdle;
        end else if (HOLD_CYCLES != 0) begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      snap_q     <= '0;
      winner_q   <= '0;
      count_q    <= '0;
      tie_q      <= 1'b0;
      no_votes_q <= 1'b0;
      total_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      winner_q   <= winner_d;
      count_q    <= count_d;
      tie_q      <= tie_d;
      no_votes_q <= no_votes_d;
      total_q    <= total_d;
      hold_q     <= hold_d;
    end
  end

  assign busy         = (state_q == StScan);
  assign result_valid = (state_q == StDone);
  assign winner       = winner_q;
  assign winner_count = count_q;
  assign tie          = tie_q;
  assign no_votes     = no_votes_q;
  assign total_votes  = total_q;

endmodule

// File: tb/tb_vote_result_resolver.sv
module tb_vote_result_resolver;

  localparam int CW = 8;

  logic          clk, reset, mode, start, ack;
  logic [CW-1:0] c1, c2, c3, c4;

  logic          a_busy, a_valid, a_tie, a_nv;
  logic [1:0]    a_winner;
  logic [CW-1:0] a_count;
  logic [CW+1:0] a_total;

  logic          b_busy, b_valid, b_tie, b_nv;
  logic [1:0]    b_winner;
  logic [CW-1:0] b_count;
  logic [CW+1:0] b_total;

  int checks   = 0;
  int failures = 0;

  vote_result_resolver #(.CNT_W(CW), .HOLD_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .start(start),
    .cand1_vote(c1), .cand2_vote(c2), .cand3_vote(c3), .cand4_vote(c4),
    .ack(ack), .busy(a_busy), .result_valid(a_valid), .winner(a_winner),
    .winner_count(a_count), .tie(a_tie), .no_votes(a_nv), .total_votes(a_total)
  );

  vote_result_resolver #(.CNT_W(CW), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .start(start),
    .cand1_vote(c1), .cand2_vote(c2), .cand3_vote(c3), .cand4_vote(c4),
    .ack(ack), .busy(b_busy), .result_valid(b_valid), .winner(b_winner),
    .winner_count(b_count), .tie(b_tie), .no_votes(b_nv), .total_votes(b_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [CW-1:0] v1, v2, v3, v4;
    int w, cnt, tie, nv, tot;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [CW-1:0] v1, v2, v3, v4);
    c1 = v1; c2 = v2; c3 = v3; c4 = v4;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_valid && n < 20);
  endtask

  initial begin
    int n;
    int seen;
    int nh;

    tbl[0] = '{8'd3,   8'd7,   8'd5,   8'd2,   1, 7,   0, 0, 17};
    tbl[1] = '{8'd9,   8'd4,   8'd9,   8'd9,   0, 9,   1, 0, 31};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   0, 0,   0, 1, 0};
    tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 0, 255, 1, 0, 1020};
    tbl[4] = '{8'd0,   8'd0,   8'd0,   8'd5,   3, 5,   0, 0, 5};
    tbl[5] = '{8'd1,   8'd2,   8'd3,   8'd4,   3, 4,   0, 0, 10};
    tbl[6] = '{8'd4,   8'd4,   8'd0,   8'd0,   0, 4,   1, 0, 8};

    reset = 1'b0; mode = 1'b0; start = 1'b0; ack = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    #2;
    chk("reset_busy", a_busy, 0);
    chk("reset_valid", a_valid, 0);
    chk("reset_total", a_total, 0);
    chk("reset_nv", a_nv, 0);
    #10 reset = 1'b1;
    tick();

    // Table-driven resolves with ack two cycles after valid.
    for (int i = 0; i < 7; i++) begin
      start_req(tbl[i].v1, tbl[i].v2, tbl[i].v3, tbl[i].v4);
      chk("busy_after_start", a_busy, 1);
      wait_valid(n);
      chk("latency", n, 5);
      chk("winner", a_winner, tbl[i].w);
      chk("winner_count", a_count, tbl[i].cnt);
      chk("tie", a_tie, tbl[i].tie);
      chk("no_votes", a_nv, tbl[i].nv);
      chk("total_votes", a_total, tbl[i].tot);
      chk("hold_inst_total", b_total, tbl[i].tot);
      tick();
      tick();
      chk("valid_held", a_valid, 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("valid_drop_after_ack", a_valid, 0);
      chk("winner_held_in_idle", a_winner, tbl[i].w);
      chk("total_held_in_idle", a_total, tbl[i].tot);
    end

    // Tallies change mid-scan: snapshot must be used.
    start_req(8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    wait_valid(n);
    chk("snap_latency", n, 4);
    chk("snap_total", a_total, 1020);
    chk("snap_tie", a_tie, 1);
    chk("snap_count", a_count, 255);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Mode drop on the third scan cycle aborts.
    start_req(8'd3, 8'd7, 8'd5, 8'd2);
    tick();
    tick();
    mode = 1'b0;
    tick();
    chk("abort_busy", a_busy, 0);
    chk("abort_valid", a_valid, 0);
    chk("abort_winner", a_winner, 0);
    chk("abort_count", a_count, 0);
    chk("abort_total", a_total, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (a_valid) seen = 1;
    end
    chk("abort_no_valid", seen, 0);
    start = 1'b1;
    tick();
    chk("start_mode0_busy", a_busy, 0);
    tick();
    chk("start_mode0_busy2", a_busy, 0);
    start = 1'b0;

    // Asynchronous reset mid-scan.
    start_req(8'd3, 8'd7, 8'd5, 8'd2);
    tick();
    tick();
    chk("pre_reset_busy", a_busy, 1);
    chk("pre_reset_total", a_total, 10);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", a_busy, 0);
    chk("async_valid", a_valid, 0);
    chk("async_winner", a_winner, 0);
    chk("async_count", a_count, 0);
    chk("async_total", a_total, 0);
    chk("async_b_busy", b_busy, 0);
    #4 reset = 1'b1;
    tick();
    chk("post_reset_busy", a_busy, 0);
    chk("post_reset_valid", a_valid, 0);

    // Timed release with HOLD_CYCLES=3 and start pulsed during DONE.
    start_req(8'd1, 8'd2, 8'd3, 8'd4);
    wait_valid(n);
    chk("hold_latency", n, 5);
    chk("hold_b_valid", b_valid, 1);
    nh = 0;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!b_valid) break;
      nh++;
      tick();
      start = 1'b0;
    end
    start = 1'b0;
    chk("hold_cycles", nh, 3);
    chk("hold_b_busy_after", b_busy, 0);
    chk("hold_b_winner", b_winner, 3);
    tick();
    chk("hold_b_no_retrigger", b_busy, 0);
    chk("hold_a_still_valid", a_valid, 1);
    mode = 1'b0;
    tick();
    chk("mode_drop_valid", a_valid, 0);
    chk("mode_drop_winner_held", a_winner, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
